inv_mix_col_seq: RTL
====================

# inv_mix_col_seq

Sequential AES-128 decryption round-tail engine. It accepts a 128-bit state and round key, applies AddRoundKey, then drives the 32-bit InvMixColumns column transform one column per cycle. It reassembles the four results into a 128-bit state for the next decryption round. It sits between the InvSubBytes/InvShiftRows stage (upstream) and the round-state register (downstream), using a valid/ready handshake on both sides.

## Interface
Parameters:
- `COLS`, 4, columns per state; fixed at 4 for AES-128; any other value is unsupported.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset; **asynchronous, active-low**.
- `in_valid`  in  1  upstream presents `in_state`, `in_key` and `in_last`.
- `in_ready`  out  1  block can accept a new state; high only in IDLE.
- `in_state`  in  128  cipher state. Byte 0 is `[127:120]`. Column c is `[127-32c -: 32]`, with row 0 at the column MSB.
- `in_key`  in  128  round key, same byte order as `in_state`.
- `in_last`  in  1  final decryption round: skip InvMixColumns and output the AddRoundKey result only.
- `out_valid`  out  1  `out_state` is valid; held until accepted.
- `out_ready`  in  1  downstream accepts `out_state`.
- `out_state`  out  128  result state.

## Operation
- FSM states:
  - IDLE: `in_ready`=1.
  - COL: column counter `col` runs 0..3.
  - DONE: `out_valid`=1.
- IDLE → COL on `in_valid & in_ready` when `in_last`=0.
  - Latch `work = in_state ^ in_key` (with `AES_ARK_FUSE_EN`).
  - Clear `col` to 0.
- IDLE → DONE on `in_valid & in_ready` when `in_last`=1.
  - Load `out_state = in_state ^ in_key`.
- COL, each cycle:
  - Column `col` of `work` passes through the FIPS-197 InvMixColumns matrix (rows 0e 0b 0d 09 / 09 0e 0b 0d / 0d 09 0e 0b / 0b 0d 09 0e).
  - GF(2^8) arithmetic with reduction polynomial 0x11B; xtime chains only, no lookup tables.
  - The result is written into column `col` of `out_state`.
- COL → DONE after `col`=3 is written. `col` is a 2-bit counter; it wraps to 0 and is not used in DONE.
- DONE → IDLE on `out_valid & out_ready`. `out_state` holds its value until the next load.
- `in_valid` outside IDLE is ignored; no input is captured.
- `out_state` columns not yet written keep their previous contents during COL. Downstream must sample only on `out_valid`.
- Input values may change after the accept edge without effect; the block holds an internal copy.

## Timing
- Reset values, applied asynchronously at `rst_n`=0:
  - state = IDLE, `col` = 0.
  - `work` = 0, `out_state` = 0.
  - `out_valid` = 0, `in_ready` = 1 after reset releases (0 during reset is acceptable; it must be 1 in the first cycle after release).
- Reset asserted mid-operation aborts the block. No output handshake occurs for the in-flight state.
- Latency is measured from the accept edge to the `out_valid` rise:
  - Normal round: 5 edges (accept, then columns 0, 1, 2, 3). `out_valid` is high after the 5th edge.
  - `in_last`=1: 1 edge. `out_valid` is high after the accept edge.
- Throughput:
  - Best case, with `out_ready` tied high: one normal round per 6 cycles, one last round per 2 cycles.
  - `in_ready` is not asserted in the DONE cycle, so there is no same-cycle accept/retire.
- Backpressure: `out_valid` and `out_state` stay stable while `out_ready`=0, for an unbounded number of cycles.

## Configuration
- `AES_ARK_FUSE_EN` defined: AddRoundKey is fused; the block XORs `in_key` into `in_state` at accept.
- `AES_ARK_FUSE_EN` undefined:
  - The `in_key` port remains but is ignored; `work = in_state`.
  - With `in_last`=1, `out_state = in_state` (pass-through).
  - Timing is unchanged.

## Test plan
- Reset: `rst_n` low mid-COL → `out_valid`=0, `out_state`=0 at once. `in_ready`=1 after release; no spurious output.
- Column vector, key=0, `in_last`=0:
  - Column 0 = 0x8e4da1bc → column 0 out 0xdb135345.
  - Column 1 = 0x9fdc589d → 0xf20a225c.
  - Columns 2–3 = 0x01010101 / 0xc6c6c6c6 → unchanged.
  - `out_valid` rises exactly 5 edges after accept.
- AddRoundKey: state = key = 0x0123…cdef repeated, `in_last`=1 → `out_state`=0 one edge after accept. Without `AES_ARK_FUSE_EN` → `out_state` = input.
- Backpressure: hold `out_ready`=0 for 10 cycles in DONE → `out_state` stable, `in_ready`=0, a new `in_valid` is ignored. Release → handshake, then IDLE.
- Busy ignore: pulse `in_valid` with different data during COL → result matches only the first accepted state.
- Back-to-back with `out_ready`=1: two normal rounds complete 6 cycles apart, both results correct.

Source files
------------

// File: rtl/inv_mix_col_seq.sv
// rtl/inv_mix_col_seq.sv - AES-128 decryption round tail: AddRoundKey, then InvMixColumns one column per cycle.
// Optional macro AES_ARK_FUSE_EN: fuse AddRoundKey (in_state ^ in_key) at accept; otherwise in_key is ignored.
module inv_mix_col_seq #(
    parameter int COLS = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    input  logic [127:0] in_key,
    input  logic         in_last,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state
);

    localparam logic [1:0] LAST_COL = 2'(COLS - 1);

    typedef enum logic [1:0] {IDLE, COL, DONE} state_t;

    state_t       state;
    logic [1:0]   col;
    logic [127:0] work;
    logic [127:0] ark;
    logic [31:0]  col_in;
    logic [31:0]  col_out;
    logic [127:0] out_next;

`ifdef AES_ARK_FUSE_EN
    assign ark = in_state ^ in_key;
`else
    logic unused_key;
    assign unused_key = ^in_key;
    assign ark = in_state;
`endif

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Each coefficient (09, 0b, 0d, 0e) is built from x, 2x, 4x, 8x of the same byte.
    function automatic logic [31:0] inv_mix(input logic [31:0] c);
        logic [7:0] a [4];
        logic [7:0] m9 [4];
        logic [7:0] mb [4];
        logic [7:0] md [4];
        logic [7:0] me [4];
        logic [7:0] x2, x4, x8;
        for (int i = 0; i < 4; i++) begin
            a[i]  = c[31-8*i -: 8];
            x2    = xt(a[i]);
            x4    = xt(x2);
            x8    = xt(x4);
            m9[i] = x8 ^ a[i];
            mb[i] = x8 ^ x2 ^ a[i];
            md[i] = x8 ^ x4 ^ a[i];
            me[i] = x8 ^ x4 ^ x2;
        end
        return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                m9[0] ^ me[1] ^ mb[2] ^ md[3],
                md[0] ^ m9[1] ^ me[2] ^ mb[3],
                mb[0] ^ md[1] ^ m9[2] ^ me[3]};
    endfunction

    always_comb begin
        col_in   = work[127:96];
        out_next = out_state;
        case (col)
            2'd0: col_in = work[127:96];
            2'd1: col_in = work[95:64];
            2'd2: col_in = work[63:32];
            2'd3: col_in = work[31:0];
            default: col_in = work[127:96];
        endcase
        col_out = inv_mix(col_in);
        case (col)
            2'd0: out_next[127:96] = col_out;
            2'd1: out_next[95:64]  = col_out;
            2'd2: out_next[63:32]  = col_out;
            2'd3: out_next[31:0]   = col_out;
            default: out_next = out_state;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            col       <= 2'd0;
            work      <= '0;
            out_state <= '0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        in_ready <= 1'b0;
                        if (in_last) begin
                            out_state <= ark;
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end else begin
                            work  <= ark;
                            col   <= 2'd0;
                            state <= COL;
                        end
                    end
                end
                COL: begin
                    out_state <= out_next;
                    col       <= col + 2'd1;
                    if (col == LAST_COL) begin
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule
